sigma_delta_dac_mc: RTL and testbench

Multi-channel first-order sigma-delta audio DAC with a sample-rate input handshake, a clock-enable divider, an oversampling sample scheduler and a soft-mute gain ramp. Per-channel 1-bit outputs feed external RC low-pass filters (10k + 100nF). The block sits between the audio mixer/stream source and the FPGA output pins. It consumes one multi-channel sample frame every OSR modulator ticks.

---
 rtl/sigma_delta_dac_mc_if.sv | 13 +
 rtl/sigma_delta_dac_mc.sv | 190 +++++++++++++++++++
 tb/tb_sigma_delta_dac_mc.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sigma_delta_dac_mc_if.sv
// Sample-frame stream handshake into the multi-channel sigma-delta DAC.
// The source drives valid/data; the DAC returns ready.
interface sigma_delta_dac_mc_if #(
    parameter int BITS     = 18,
    parameter int CHANNELS = 2
);
    logic                     s_valid;
    logic                     s_ready;
    logic [CHANNELS*BITS-1:0] s_data;

    modport master (output s_valid, output s_data, input s_ready);
    modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/sigma_delta_dac_mc.sv
// Multi-channel first-order sigma-delta DAC with a one-frame input buffer and soft-mute gain ramp.
// Optional LSB dither from a 16-bit LFSR is enabled by defining SD_DITHER_EN.
module sigma_delta_dac_mc #(
    parameter int BITS      = 18,
    parameter int CHANNELS  = 2,
    parameter int CLK_DIV   = 1,
    parameter int OSR       = 256,
    parameter int GAIN_BITS = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    sigma_delta_dac_mc_if.slave     s,
    input  logic                    mute,
    input  logic                    underrun_clr,
    output logic                    muted,
    output logic                    underrun,
    output logic [CHANNELS-1:0]     audio_out
);
    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int CNT_W  = $clog2(OSR);
    localparam int SL_W   = BITS + 2;
    localparam int PROD_W = BITS + GAIN_BITS + 3;
    localparam logic [BITS-1:0]      MIDSCALE = {1'b1, {(BITS-1){1'b0}}};
    localparam logic [GAIN_BITS:0]   UNITY    = {1'b1, {GAIN_BITS{1'b0}}};
    localparam logic [GAIN_BITS:0]   G_ZERO   = '0;

    typedef enum logic [1:0] {RUN, RAMP_DOWN, MUTED, RAMP_UP} gain_state_t;

    logic [DIV_W-1:0]          div_reg;
    logic [CNT_W-1:0]          cnt_reg;
    logic                      mod_tick;
    logic                      samp_tick;
    logic                      scale_en_reg;
    logic [CHANNELS*BITS-1:0]  pend_reg;
    logic                      pend_full_reg;
    logic                      accept;
    logic                      underrun_reg;
    gain_state_t               state_reg, state_next;
    logic [GAIN_BITS:0]        g_reg, g_next;
    logic [GAIN_BITS:0]        g_dn, g_up;

    assign mod_tick  = (div_reg == DIV_W'(CLK_DIV - 1));
    assign samp_tick = mod_tick && (cnt_reg == CNT_W'(OSR - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_reg      <= '0;
            cnt_reg      <= '0;
            scale_en_reg <= 1'b0;
        end else begin
            div_reg      <= mod_tick ? '0 : div_reg + 1'b1;
            scale_en_reg <= samp_tick;
            if (mod_tick)
                cnt_reg <= samp_tick ? '0 : cnt_reg + 1'b1;
        end
    end

    // One-entry pending buffer; a full buffer blocks acceptance, so no accept can
    // collide with the frame-boundary transfer.
    assign s.s_ready = !pend_full_reg;
    assign accept    = s.s_valid && !pend_full_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_reg      <= '0;
            pend_full_reg <= 1'b0;
        end else if (accept) begin
            pend_reg      <= s.s_data;
            pend_full_reg <= 1'b1;
        end else if (samp_tick) begin
            pend_full_reg <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            underrun_reg <= 1'b0;
        else if (samp_tick && !pend_full_reg)
            underrun_reg <= 1'b1;
        else if (underrun_clr)
            underrun_reg <= 1'b0;
    end

    assign underrun = underrun_reg;
    assign muted    = (state_reg == MUTED);

    // Saturating gain steps; the direction at each frame boundary follows mute.
    assign g_dn = (g_reg == G_ZERO) ? G_ZERO : g_reg - 1'b1;
    assign g_up = (g_reg == UNITY)  ? UNITY  : g_reg + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= RUN;
            g_reg     <= UNITY;
        end else begin
            state_reg <= state_next;
            g_reg     <= g_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        g_next     = g_reg;
        if (samp_tick) begin
            case (state_reg)
                RUN, RAMP_UP: begin
                    if (mute) begin
                        g_next     = g_dn;
                        state_next = (g_dn == G_ZERO) ? MUTED : RAMP_DOWN;
                    end else begin
                        g_next     = g_up;
                        state_next = (g_up == UNITY) ? RUN : RAMP_UP;
                    end
                end
                RAMP_DOWN, MUTED: begin
                    if (mute) begin
                        g_next     = g_dn;
                        state_next = (g_dn == G_ZERO) ? MUTED : RAMP_DOWN;
                    end else begin
                        g_next     = g_up;
                        state_next = (g_up == UNITY) ? RUN : RAMP_UP;
                    end
                end
                default: begin
                    g_next     = UNITY;
                    state_next = RUN;
                end
            endcase
        end
    end

`ifdef SD_DITHER_EN
    logic [15:0] lfsr_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            lfsr_reg <= 16'hACE1;
        else if (mod_tick)
            lfsr_reg <= {lfsr_reg[14:0], lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10]};
    end
`endif

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
        logic [BITS-1:0]          active_reg;
        logic [BITS-1:0]          scaled_reg;
        logic [BITS-1:0]          scaled_next;
        logic [SL_W-1:0]          sl_reg;
        logic                     audio_reg;
        logic signed [BITS:0]     d;
        logic signed [PROD_W-1:0] d_ext;
        logic signed [PROD_W-1:0] g_ext;
        logic signed [PROD_W-1:0] prod;
        logic [SL_W-1:0]          dat_q;
        logic [SL_W-1:0]          delta_b;

        // Gain is applied around midscale; >>> floors toward negative infinity.
        assign d           = $signed({1'b0, active_reg}) - $signed({1'b0, MIDSCALE});
        assign d_ext       = PROD_W'(d);
        assign g_ext       = PROD_W'({1'b0, g_reg});
        assign prod        = d_ext * g_ext;
        assign scaled_next = MIDSCALE + BITS'(prod >>> GAIN_BITS);

`ifdef SD_DITHER_EN
        assign dat_q = {2'b00, scaled_reg} + SL_W'(lfsr_reg[gi % 16]);
`else
        assign dat_q = {2'b00, scaled_reg};
`endif
        assign delta_b = {sl_reg[SL_W-1], sl_reg[SL_W-1], {BITS{1'b0}}};

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                active_reg <= MIDSCALE;
                scaled_reg <= MIDSCALE;
                sl_reg     <= {1'b1, {(SL_W-1){1'b0}}};
                audio_reg  <= 1'b0;
            end else begin
                if (samp_tick && pend_full_reg)
                    active_reg <= pend_reg[gi*BITS +: BITS];
                if (scale_en_reg)
                    scaled_reg <= scaled_next;
                if (mod_tick) begin
                    sl_reg    <= sl_reg + dat_q + delta_b;
                    audio_reg <= sl_reg[SL_W-1];
                end
            end
        end

        assign audio_out[gi] = audio_reg;
    end
endmodule

// File: tb/tb_sigma_delta_dac_mc.sv
// Directed bench for sigma_delta_dac_mc: two instances (tick every clk / every 3 clks),
// both with OSR=4 and GAIN_BITS=4 so frame boundaries and gain ramps are short.
module tb_sigma_delta_dac_mc;
`ifdef SD_DITHER_EN
    localparam int TOL = 4;
`else
    localparam int TOL = 1;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       mute_a, clr_a, muted_a, underrun_a;
    logic       mute_b, clr_b, muted_b, underrun_b;
    logic [1:0] audio_a, audio_b;
    int         cyc;
    int         n_checks = 0;
    int         n_fail   = 0;

    sigma_delta_dac_mc_if #(.BITS(18), .CHANNELS(2)) bus_a ();
    sigma_delta_dac_mc_if #(.BITS(18), .CHANNELS(2)) bus_b ();

    sigma_delta_dac_mc #(.BITS(18), .CHANNELS(2), .CLK_DIV(1), .OSR(4), .GAIN_BITS(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .s(bus_a), .mute(mute_a), .underrun_clr(clr_a),
        .muted(muted_a), .underrun(underrun_a), .audio_out(audio_a));

    sigma_delta_dac_mc #(.BITS(18), .CHANNELS(2), .CLK_DIV(3), .OSR(4), .GAIN_BITS(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .s(bus_b), .mute(mute_b), .underrun_clr(clr_b),
        .muted(muted_b), .underrun(underrun_b), .audio_out(audio_b));

    always #5 clk = ~clk;

    // Edges since reset release: dut_a frame boundary when cyc%4==0, dut_b tick when cyc%3==0.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic goto_a(input int r);
        do step(); while ((cyc % 4) != r);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({audio_a, bus_a.s_ready, underrun_a, muted_a} !== 5'b00100) begin
            n_fail++; $display("FAIL reset_a: got %b expected 00100", {audio_a, bus_a.s_ready, underrun_a, muted_a});
        end
        n_checks++;
        if ({audio_b, bus_b.s_ready, underrun_b, muted_b} !== 5'b00100) begin
            n_fail++; $display("FAIL reset_b: got %b expected 00100", {audio_b, bus_b.s_ready, underrun_b, muted_b});
        end
        rst_n = 1'b1;
        goto_a(0);
        n_checks++;
        if (underrun_a !== 1'b1) begin
            n_fail++; $display("FAIL underrun_first_boundary: got %b expected 1", underrun_a);
        end
        bus_a.s_valid = 1'b1;
        bus_a.s_data  = {18'h11111, 18'h22222};
        step();
        bus_a.s_valid = 1'b0;
        n_checks++;
        if (bus_a.s_ready !== 1'b0) begin
            n_fail++; $display("FAIL ready_after_accept: got %b expected 0", bus_a.s_ready);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({audio_a, bus_a.s_ready, underrun_a, muted_a} !== 5'b00100) begin
            n_fail++; $display("FAIL async_reset: got %b expected 00100", {audio_a, bus_a.s_ready, underrun_a, muted_a});
        end
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        $display("test_reset done, cyc=%0d", cyc);
    endtask

    task automatic test_density();
        int ones0, ones1;
        ones0 = 0;
        ones1 = 0;
        bus_a.s_valid = 1'b1;
        bus_a.s_data  = {18'h30000, 18'h20000};
        repeat (16) step();
        for (int i = 0; i < 1024; i++) begin
            step();
            ones0 += int'(audio_a[0]);
            ones1 += int'(audio_a[1]);
        end
        n_checks++;
        if (ones0 < 512 - TOL || ones0 > 512 + TOL) begin
            n_fail++; $display("FAIL density_ch0: got %0d expected 512+-%0d", ones0, TOL);
        end
        n_checks++;
        if (ones1 < 768 - TOL || ones1 > 768 + TOL) begin
            n_fail++; $display("FAIL density_ch1: got %0d expected 768+-%0d", ones1, TOL);
        end
        n_checks++;
        if (underrun_a !== 1'b0) begin
            n_fail++; $display("FAIL density_underrun: got %b expected 0", underrun_a);
        end
        $display("test_density ones ch0=%0d ch1=%0d", ones0, ones1);
    endtask

    task automatic test_back_to_back();
        logic [35:0] fr [3];
        fr[0] = {18'h2ABCD, 18'h10000};
        fr[1] = {18'h00000, 18'h3FFFF};
        fr[2] = {18'h30000, 18'h20000};
        goto_a(0);
        bus_a.s_data = fr[0];
        for (int f = 0; f < 3; f++) begin
            step();
            n_checks++;
            if (bus_a.s_ready !== 1'b0) begin
                n_fail++; $display("FAIL b2b_accept_%0d: ready got %b expected 0", f, bus_a.s_ready);
            end
            if (f > 0) begin
                n_checks++;
                if ({dut_a.g_chan[1].scaled_reg, dut_a.g_chan[0].scaled_reg} !== fr[f-1]) begin
                    n_fail++; $display("FAIL b2b_active_%0d: got %h expected %h", f - 1,
                        {dut_a.g_chan[1].scaled_reg, dut_a.g_chan[0].scaled_reg}, fr[f-1]);
                end
            end
            if (f < 2) bus_a.s_data = fr[f+1];
            else       bus_a.s_valid = 1'b0;
            for (int k = 0; k < 2; k++) begin
                step();
                n_checks++;
                if (bus_a.s_ready !== 1'b0) begin
                    n_fail++; $display("FAIL b2b_hold_%0d_%0d: ready got %b expected 0", f, k, bus_a.s_ready);
                end
            end
            step();
            n_checks++;
            if (bus_a.s_ready !== 1'b1) begin
                n_fail++; $display("FAIL b2b_release_%0d: ready got %b expected 1", f, bus_a.s_ready);
            end
        end
        step();
        n_checks++;
        if ({dut_a.g_chan[1].scaled_reg, dut_a.g_chan[0].scaled_reg} !== fr[2]) begin
            n_fail++; $display("FAIL b2b_active_2: got %h expected %h",
                {dut_a.g_chan[1].scaled_reg, dut_a.g_chan[0].scaled_reg}, fr[2]);
        end
        $display("test_back_to_back done");
    endtask

    task automatic test_underrun();
        int ones0, ones1;
        ones0 = 0;
        ones1 = 0;
        n_checks++;
        if (underrun_a !== 1'b0) begin
            n_fail++; $display("FAIL underrun_pre: got %b expected 0", underrun_a);
        end
        goto_a(0);
        n_checks++;
        if (underrun_a !== 1'b1) begin
            n_fail++; $display("FAIL underrun_set: got %b expected 1", underrun_a);
        end
        for (int i = 0; i < 64; i++) begin
            step();
            ones0 += int'(audio_a[0]);
            ones1 += int'(audio_a[1]);
        end
        n_checks++;
        if (ones0 < 32 - TOL || ones0 > 32 + TOL || ones1 < 48 - TOL || ones1 > 48 + TOL) begin
            n_fail++; $display("FAIL underrun_density: got %0d/%0d expected 32/48", ones0, ones1);
        end
        n_checks++;
        if ({dut_a.g_chan[1].scaled_reg, dut_a.g_chan[0].scaled_reg} !== {18'h30000, 18'h20000}) begin
            n_fail++; $display("FAIL underrun_held: got %h expected %h",
                {dut_a.g_chan[1].scaled_reg, dut_a.g_chan[0].scaled_reg}, {18'h30000, 18'h20000});
        end
        goto_a(0);
        clr_a = 1'b1;
        step();
        clr_a = 1'b0;
        n_checks++;
        if (underrun_a !== 1'b0) begin
            n_fail++; $display("FAIL underrun_clear: got %b expected 0", underrun_a);
        end
        goto_a(3);
        clr_a = 1'b1;
        step();
        clr_a = 1'b0;
        n_checks++;
        if (underrun_a !== 1'b1) begin
            n_fail++; $display("FAIL underrun_set_wins: got %b expected 1", underrun_a);
        end
        $display("test_underrun ones ch0=%0d ch1=%0d", ones0, ones1);
    endtask

    task automatic test_gain_ramp();
        goto_a(0);
        bus_a.s_valid = 1'b1;
        bus_a.s_data  = {18'h00001, 18'h3FFFF};
        goto_a(0);
        mute_a = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            goto_a(0);
            n_checks++;
            if (dut_a.g_reg !== 5'(16 - i) || muted_a !== 1'b0) begin
                n_fail++; $display("FAIL ramp_down_part_%0d: g=%0d muted=%b expected g=%0d muted=0", i, dut_a.g_reg, muted_a, 16 - i);
            end
        end
        step();
        n_checks++;
        if ({dut_a.g_chan[1].scaled_reg, dut_a.g_chan[0].scaled_reg} !== {18'h10000, 18'h2FFFF}) begin
            n_fail++; $display("FAIL scaled_g8: got %h expected %h",
                {dut_a.g_chan[1].scaled_reg, dut_a.g_chan[0].scaled_reg}, {18'h10000, 18'h2FFFF});
        end
        mute_a = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            goto_a(0);
            n_checks++;
            if (dut_a.g_reg !== 5'(8 + i) || muted_a !== 1'b0) begin
                n_fail++; $display("FAIL ramp_up_%0d: g=%0d muted=%b expected g=%0d muted=0", i, dut_a.g_reg, muted_a, 8 + i);
            end
        end
        step();
        n_checks++;
        if ({dut_a.g_chan[1].scaled_reg, dut_a.g_chan[0].scaled_reg} !== {18'h00001, 18'h3FFFF}) begin
            n_fail++; $display("FAIL scaled_unity: got %h expected %h",
                {dut_a.g_chan[1].scaled_reg, dut_a.g_chan[0].scaled_reg}, {18'h00001, 18'h3FFFF});
        end
        mute_a = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            goto_a(0);
            n_checks++;
            if (dut_a.g_reg !== 5'(16 - i) || muted_a !== (i == 16)) begin
                n_fail++; $display("FAIL ramp_down_%0d: g=%0d muted=%b expected g=%0d", i, dut_a.g_reg, muted_a, 16 - i);
            end
        end
        step();
        n_checks++;
        if ({dut_a.g_chan[1].scaled_reg, dut_a.g_chan[0].scaled_reg} !== {18'h20000, 18'h20000}) begin
            n_fail++; $display("FAIL scaled_muted: got %h expected %h",
                {dut_a.g_chan[1].scaled_reg, dut_a.g_chan[0].scaled_reg}, {18'h20000, 18'h20000});
        end
        goto_a(0);
        n_checks++;
        if (dut_a.g_reg !== 5'd0 || muted_a !== 1'b1) begin
            n_fail++; $display("FAIL muted_hold: g=%0d muted=%b expected g=0 muted=1", dut_a.g_reg, muted_a);
        end
        mute_a = 1'b0;
        goto_a(0);
        n_checks++;
        if (dut_a.g_reg !== 5'd1 || muted_a !== 1'b0) begin
            n_fail++; $display("FAIL unmute_step: g=%0d muted=%b expected g=1 muted=0", dut_a.g_reg, muted_a);
        end
        $display("test_gain_ramp done");
    endtask

    task automatic test_clk_div_reset();
        int         ones, off_tick;
        logic [1:0] prev;
        ones     = 0;
        off_tick = 0;
        mute_b   = 1'b1;
        repeat (40) step();
        n_checks++;
        if (dut_b.g_reg >= 5'd16) begin
            n_fail++; $display("FAIL div_midramp: g=%0d expected below 16", dut_b.g_reg);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (dut_b.g_reg !== 5'd16 || muted_b !== 1'b0 || audio_b !== 2'b00) begin
            n_fail++; $display("FAIL div_reset: g=%0d muted=%b audio=%b expected 16/0/00", dut_b.g_reg, muted_b, audio_b);
        end
        mute_b = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        prev  = audio_b;
        for (int i = 0; i < 3072; i++) begin
            step();
            if (audio_b != prev && (cyc % 3) != 0) off_tick++;
            if ((cyc % 3) == 0) ones += int'(audio_b[0]);
            prev = audio_b;
        end
        n_checks++;
        if (off_tick != 0) begin
            n_fail++; $display("FAIL div_off_tick_changes: got %0d expected 0", off_tick);
        end
        n_checks++;
        if (ones < 512 - TOL || ones > 512 + TOL) begin
            n_fail++; $display("FAIL div_density: got %0d expected 512+-%0d", ones, TOL);
        end
        n_checks++;
        if (dut_b.g_reg !== 5'd16 || muted_b !== 1'b0) begin
            n_fail++; $display("FAIL div_run_state: g=%0d muted=%b expected 16/0", dut_b.g_reg, muted_b);
        end
        $display("test_clk_div_reset ones=%0d off_tick=%0d", ones, off_tick);
    endtask

    initial begin
        rst_n         = 1'b0;
        mute_a        = 1'b0;
        clr_a         = 1'b0;
        mute_b        = 1'b0;
        clr_b         = 1'b0;
        bus_a.s_valid = 1'b0;
        bus_a.s_data  = '0;
        bus_b.s_valid = 1'b1;
        bus_b.s_data  = {18'h20000, 18'h20000};
        test_reset();
        test_density();
        test_back_to_back();
        test_underrun();
        test_gain_ramp();
        test_clk_div_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
